// File: rtl/bip_program_loader.sv
// Purpose : packs a little-endian UART byte stream into 16-bit words and writes them to program memory from address 0.
// Latency : second byte strobe at cycle n -> o_pm_wr at n+1; for the HALT word o_enable rises at n+2.
// Backpressure: none; bytes are strobed, and a byte arriving during the one-cycle WRITE slot is dropped.
//
// Ports:
//   i_clk, i_reset (async, active-low)
//   i_load      : pulse, starts a new load from IDLE/DONE/ERROR
//   i_rx_data/i_rx_valid : UART byte and its one-cycle strobe
//   i_cpu_halt  : CPU halted (level), honoured only in RUN
//   o_pm_wr/o_pm_addr/o_pm_data : program memory write port
//   o_enable, o_busy, o_done, o_error : registered status
//
// Optional build macro: BIP_LOADER_CHECKSUM_EN
//   Adds an 8-bit XOR of every loaded byte. After the HALT word, one extra byte is
//   expected; if it matches, the CPU is released, otherwise the loader goes to ERROR.

module bip_program_loader #(
  parameter int            NBITS_O = 11,
  parameter int            NBITS_D = 16,
  parameter int            NBITS_B = 8,
  parameter int            OPCODE  = 5,
  parameter logic [OPCODE-1:0] HALT_OP = 5'b00000,
  parameter int            CELDAS  = 512
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic [NBITS_B-1:0] i_rx_data,
  input  logic               i_rx_valid,
  input  logic               i_cpu_halt,
  output logic               o_pm_wr,
  output logic [NBITS_O-1:0] o_pm_addr,
  output logic [NBITS_D-1:0] o_pm_data,
  output logic               o_enable,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_error
);

  localparam logic [NBITS_O-1:0] LAST_ADDR = NBITS_O'(CELDAS - 1);

`ifdef BIP_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_RECV_LO, S_RECV_HI, S_WRITE, S_RUN, S_DONE, S_ERROR, S_CHK
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_RECV_LO, S_RECV_HI, S_WRITE, S_RUN, S_DONE, S_ERROR
  } state_t;
`endif

  state_t               r_state;
  logic [NBITS_O-1:0]   r_cnt;
  logic [NBITS_B-1:0]   r_lo;
  logic                 r_pm_wr;
  logic [NBITS_O-1:0]   r_pm_addr;
  logic [NBITS_D-1:0]   r_pm_data;
  logic                 r_enable;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_error;
`ifdef BIP_LOADER_CHECKSUM_EN
  logic [NBITS_B-1:0]   r_csum;
`endif

  // The word being written in WRITE is the one just assembled into r_pm_data.
  logic w_is_halt;
  assign w_is_halt = (r_pm_data[NBITS_D-1 -: OPCODE] == HALT_OP);

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_lo      <= '0;
      r_pm_wr   <= 1'b0;
      r_pm_addr <= '0;
      r_pm_data <= '0;
      r_enable  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
      r_csum    <= '0;
`endif
    end else begin
      // Write strobe is high only for the single WRITE cycle.
      r_pm_wr <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (i_load) begin
            r_state <= S_RECV_LO;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_error <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
          end
        end
        S_RECV_LO: begin
          if (i_rx_valid) begin
            r_lo    <= i_rx_data;
            r_state <= S_RECV_HI;
`ifdef BIP_LOADER_CHECKSUM_EN
            r_csum  <= r_csum ^ i_rx_data;
`endif
          end
        end
        S_RECV_HI: begin
          if (i_rx_valid) begin
            r_pm_data <= {i_rx_data, r_lo};
            r_pm_addr <= r_cnt;
            r_pm_wr   <= 1'b1;
            r_state   <= S_WRITE;
`ifdef BIP_LOADER_CHECKSUM_EN
            r_csum    <= r_csum ^ i_rx_data;
`endif
          end
        end
        S_WRITE: begin
          if (w_is_halt) begin
`ifdef BIP_LOADER_CHECKSUM_EN
            r_state  <= S_CHK;
`else
            r_state  <= S_RUN;
            r_busy   <= 1'b0;
            r_enable <= 1'b1;
`endif
          end else if (r_cnt == LAST_ADDR) begin
            // Memory full with no HALT seen; last word has already been written.
            r_state <= S_ERROR;
            r_busy  <= 1'b0;
            r_error <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_state <= S_RECV_LO;
          end
        end
`ifdef BIP_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (i_rx_valid) begin
            r_busy <= 1'b0;
            if (i_rx_data == r_csum) begin
              r_state  <= S_RUN;
              r_enable <= 1'b1;
            end else begin
              r_state <= S_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        S_RUN: begin
          if (i_cpu_halt) begin
            r_state  <= S_DONE;
            r_enable <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_busy   <= 1'b0;
          r_enable <= 1'b0;
        end
      endcase
    end
  end

  assign o_pm_wr   = r_pm_wr;
  assign o_pm_addr = r_pm_addr;
  assign o_pm_data = r_pm_data;
  assign o_enable  = r_enable;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_error   = r_error;

endmodule

// File: tb/tb_bip_program_loader.sv
// Purpose : self-checking bench for bip_program_loader (table vectors, corner sequences, randomized loads).
// Latency : checks outputs 1 time unit after each rising edge; write monitor samples on falling edges.
// Backpressure: none; stimulus respects the one-cycle WRITE slot after every high byte.

module tb_bip_program_loader;

  localparam int DEPTH = 4;
`ifdef BIP_LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_load = 1'b0;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_cpu_halt = 1'b0;
  logic        o_pm_wr;
  logic [10:0] o_pm_addr;
  logic [15:0] o_pm_data;
  logic        o_enable;
  logic        o_busy;
  logic        o_done;
  logic        o_error;

  bip_program_loader #(.CELDAS(DEPTH)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (i_load),
    .i_rx_data  (i_rx_data),
    .i_rx_valid (i_rx_valid),
    .i_cpu_halt (i_cpu_halt),
    .o_pm_wr    (o_pm_wr),
    .o_pm_addr  (o_pm_addr),
    .o_pm_data  (o_pm_data),
    .o_enable   (o_enable),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_error    (o_error)
  );

  always #5 i_clk = ~i_clk;

  int nvec = 0;
  int nerr = 0;

  typedef struct packed {
    logic        ld;
    logic        rv;
    logic [7:0]  rd;
    logic        hlt;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [18];

  function automatic logic [31:0] mk(logic wr, logic [10:0] a, logic [15:0] d,
                                     logic en, logic bsy, logic dn, logic er);
    return {wr, a, d, en, bsy, dn, er};
  endfunction

  function automatic logic [31:0] outs();
    return {o_pm_wr, o_pm_addr, o_pm_data, o_enable, o_busy, o_done, o_error};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic step(input logic ld, input logic rv, input logic [7:0] rd, input logic hlt);
    i_load = ld; i_rx_valid = rv; i_rx_data = rd; i_cpu_halt = hlt;
    @(posedge i_clk); #1;
    i_load = 1'b0; i_rx_valid = 1'b0; i_cpu_halt = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic do_reset();
    i_reset = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
  endtask

  // Write monitor for the randomized phase: every strobe must match the next expected write.
  bit          mon_en = 1'b0;
  logic [10:0] q_addr [$];
  logic [15:0] q_data [$];
  int          wrcnt = 0;

  always @(negedge i_clk) begin
    if (mon_en && o_pm_wr) begin
      wrcnt++;
      if (q_addr.size() == 0) begin
        chk("unexpected_write", {5'b0, o_pm_addr, o_pm_data}, 32'hFFFFFFFF);
      end else begin
        chk("rand_write", {5'b0, o_pm_addr, o_pm_data}, {5'b0, q_addr[0], q_data[0]});
        void'(q_addr.pop_front());
        void'(q_data.pop_front());
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    repeat ($urandom_range(0, 2)) idle();
    step(1'b0, 1'b1, b, 1'b0);
  endtask

  initial begin
    // Three-word load, run/halt, ignored events, reload at address 0.
    tbl[0]  = '{1'b0, 1'b1, 8'h55, 1'b0, mk(0, 0, 16'h0000, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, mk(0, 0, 16'h0000, 0, 1, 0, 0)};
    tbl[2]  = '{1'b0, 1'b1, 8'h01, 1'b0, mk(0, 0, 16'h0000, 0, 1, 0, 0)};
    tbl[3]  = '{1'b0, 1'b1, 8'h08, 1'b0, mk(1, 0, 16'h0801, 0, 1, 0, 0)};
    tbl[4]  = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0, 0, 16'h0801, 0, 1, 0, 0)};
    tbl[5]  = '{1'b0, 1'b1, 8'h02, 1'b0, mk(0, 0, 16'h0801, 0, 1, 0, 0)};
    tbl[6]  = '{1'b0, 1'b1, 8'h10, 1'b0, mk(1, 1, 16'h1002, 0, 1, 0, 0)};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0, 1, 16'h1002, 0, 1, 0, 0)};
    tbl[8]  = '{1'b0, 1'b1, 8'h00, 1'b0, mk(0, 1, 16'h1002, 0, 1, 0, 0)};
    tbl[9]  = '{1'b0, 1'b1, 8'h00, 1'b0, mk(1, 2, 16'h0000, 0, 1, 0, 0)};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, mk(0, 2, 16'h0000, !CSUM, CSUM, 0, 0)};
    tbl[11] = '{1'b0, 1'b1, 8'h1B, 1'b0, mk(0, 2, 16'h0000, 1, 0, 0, 0)};
    tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, mk(0, 2, 16'h0000, 1, 0, 0, 0)};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, mk(0, 2, 16'h0000, 0, 0, 1, 0)};
    tbl[14] = '{1'b0, 1'b1, 8'h77, 1'b1, mk(0, 2, 16'h0000, 0, 0, 1, 0)};
    tbl[15] = '{1'b1, 1'b0, 8'h00, 1'b0, mk(0, 2, 16'h0000, 0, 1, 0, 0)};
    tbl[16] = '{1'b0, 1'b1, 8'h34, 1'b0, mk(0, 2, 16'h0000, 0, 1, 0, 0)};
    tbl[17] = '{1'b0, 1'b1, 8'h12, 1'b0, mk(1, 0, 16'h1234, 0, 1, 0, 0)};

    do_reset();
    chk("reset_state", outs(), mk(0, 0, 16'h0000, 0, 0, 0, 0));

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].ld, tbl[i].rv, tbl[i].rd, tbl[i].hlt);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    idle();

    // Reset in the middle of RECV_HI: outputs clear without a clock edge.
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("pre_reset_busy", outs(), mk(0, 0, 16'h1234, 0, 1, 0, 0));
    #2 i_reset = 1'b0;
    #1 chk("async_reset", outs(), mk(0, 0, 16'h0000, 0, 0, 0, 0));
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk); #1;
    step(1'b0, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 8'h08, 1'b0);
    chk("idle_ignores_bytes", outs(), mk(0, 0, 16'h0000, 0, 0, 0, 0));

    // Overflow: DEPTH non-HALT words fill memory and raise error.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int k = 0; k < DEPTH; k++) begin
      step(1'b0, 1'b1, 8'h01, 1'b0);
      step(1'b0, 1'b1, 8'h08, 1'b0);
      chk($sformatf("ovf_write%0d", k), outs(), mk(1, 11'(k), 16'h0801, 0, 1, 0, 0));
      idle();
      if (k < DEPTH - 1)
        chk($sformatf("ovf_after%0d", k), outs(), mk(0, 11'(k), 16'h0801, 0, 1, 0, 0));
      else
        chk("ovf_error", outs(), mk(0, 11'(k), 16'h0801, 0, 0, 0, 1));
    end
    step(1'b0, 1'b1, 8'h01, 1'b0);
    chk("error_ignores_bytes", outs(), mk(0, 3, 16'h0801, 0, 0, 0, 1));
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("error_recover", outs(), mk(0, 3, 16'h0801, 0, 1, 0, 0));

`ifdef BIP_LOADER_CHECKSUM_EN
    // Good checksum then bad checksum on the same two-word program.
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1) step(1'b1, 1'b0, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h01, 1'b0);
      step(1'b0, 1'b1, 8'h08, 1'b0);
      idle();
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);
      idle();
      chk($sformatf("chk_wait%0d", pass), outs(), mk(0, 1, 16'h0000, 0, 1, 0, 0));
      step(1'b0, 1'b1, (pass == 0) ? 8'h09 : 8'h0A, 1'b0);
      if (pass == 0) begin
        chk("chk_good", outs(), mk(0, 1, 16'h0000, 1, 0, 0, 0));
        step(1'b0, 1'b0, 8'h00, 1'b1);
      end else begin
        chk("chk_bad", outs(), mk(0, 1, 16'h0000, 0, 0, 0, 1));
        idle();
        chk("chk_bad_hold", outs(), mk(0, 1, 16'h0000, 0, 0, 0, 1));
      end
    end
`endif

    // Randomized loads against a program-level model.
    do_reset();
    mon_en = 1'b1;
    for (int t = 0; t < 40; t++) begin
      logic [15:0] w;
      logic [7:0]  xs;
      bit          stop;
      bit          run;
      int          nexp;
      stop = 1'b0; run = 1'b0; nexp = 0; xs = 8'h00;
      wrcnt = 0;
      step(1'b1, 1'b0, 8'h00, 1'b0);
      for (int i = 0; i < DEPTH; i++) begin
        if (!stop) begin
          if ($urandom_range(0, 3) == 0) w = {5'b00000, 11'($urandom)};
          else                           w = {5'($urandom_range(1, 31)), 11'($urandom)};
          q_addr.push_back(11'(i));
          q_data.push_back(w);
          nexp++;
          xs = xs ^ w[7:0] ^ w[15:8];
          send_byte(w[7:0]);
          send_byte(w[15:8]);
          idle();
          if (w[15:11] == 5'b00000) begin
            stop = 1'b1;
            run  = 1'b1;
          end
        end
      end
      if (run && CSUM) begin
        if ($urandom_range(0, 2) != 0) send_byte(xs);
        else begin
          send_byte(xs ^ 8'($urandom_range(1, 255)));
          run = 1'b0;
        end
      end
      idle();
      send_byte(8'($urandom));
      idle();
      chk($sformatf("rand_end%0d", t), outs() & 32'h0000000F, {28'h0, run, 1'b0, 1'b0, !run});
      chk($sformatf("rand_count%0d", t), 32'(wrcnt), 32'(nexp));
      if (run) begin
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk($sformatf("rand_done%0d", t), outs() & 32'h0000000F, 32'h2);
      end
    end
    mon_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/bip_program_loader.md
Name: bip_program_loader

Overview:
- Upstream stage of the BIP processor: takes a byte stream from the UART receiver and packs it into 16-bit instruction words.
- Writes the words sequentially into program memory starting at address 0.
- On receiving the HALT instruction, releases the CPU by asserting o_enable.
- When the CPU reports halt, returns to a done state, ready to accept a reload.

Parameters:
NBITS_O, 11, program memory address width
NBITS_D, 16, instruction word width (2 bytes)
NBITS_B, 8, UART byte width
OPCODE, 5, opcode field width, located at bits [NBITS_D-1 -: OPCODE]
HALT_OP, 5'b00000, opcode value that terminates a load
CELDAS, 512, program memory depth in words

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_load  in  1  one-cycle pulse that starts a new program load
i_rx_data  in  NBITS_B  received UART byte
i_rx_valid  in  1  one-cycle strobe; i_rx_data is valid this cycle
i_cpu_halt  in  1  CPU has executed HALT (level)
o_pm_wr  out  1  program memory write strobe
o_pm_addr  out  NBITS_O  program memory write address
o_pm_data  out  NBITS_D  program memory write data
o_enable  out  1  CPU run enable
o_busy  out  1  high while a load is in progress
o_done  out  1  high in DONE state
o_error  out  1  high in ERROR state

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, word counter=0.
  - All outputs 0: o_pm_wr, o_pm_addr, o_pm_data, o_enable, o_busy, o_done, o_error.
- States: IDLE, RECV_LO, RECV_HI, WRITE, RUN, DONE, ERROR.
- IDLE/DONE/ERROR: on i_load -> RECV_LO.
  - Word counter and checksum are cleared.
  - o_done and o_error are cleared.
- RECV_LO: on i_rx_valid, latch i_rx_data into data[7:0] -> RECV_HI. Byte order is little-endian.
- RECV_HI: on i_rx_valid, latch into data[15:8] -> WRITE.
- WRITE: exactly one cycle.
  - o_pm_wr=1, o_pm_addr=counter, o_pm_data=assembled word.
  - Next state:
    - Opcode==HALT_OP -> RUN (or CHK state when the optional feature is enabled).
    - Else if counter==CELDAS-1 -> ERROR (memory full without HALT; the word is still written).
    - Else counter+1 -> RECV_LO.
- RUN: o_enable=1. When i_cpu_halt=1, o_enable drops next cycle -> DONE.
- o_busy=1 in RECV_LO, RECV_HI, WRITE and CHK.
- Registered outputs:
  - o_enable, o_done and o_error reflect the state register.
  - o_pm_addr/o_pm_data hold their last value outside WRITE.
- Latency: second byte strobe at cycle n -> o_pm_wr at n+1.
  - For a HALT word, o_enable rises at n+2.
- Boundary conditions:
  - i_rx_valid while in IDLE/RUN/DONE/ERROR: ignored.
  - i_load while in RUN: ignored; the CPU must halt first.
  - i_load in RECV_*/WRITE: ignored, load continues.
  - i_rx_valid in WRITE: byte dropped. The UART byte period is far longer than 1 cycle, so this cannot occur in-system.
  - i_cpu_halt outside RUN: ignored.
  - Reset mid-load: immediate return to IDLE, o_pm_wr=0. Partially written memory is not cleared.
- Counter width: NBITS_O. CELDAS <= 2**NBITS_O; counter never wraps.

Optional Feature:
- Macro: BIP_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR covers every byte latched in RECV_LO/RECV_HI.
  - After the HALT word is written, the FSM enters CHK (o_busy=1) and waits for one more byte.
  - Byte equals running XOR -> RUN; otherwise -> ERROR with o_enable never asserted.
- Undefined: no CHK state; the HALT word goes directly to RUN; no checksum logic is synthesized.

Test Plan:
- Reset: assert i_reset=0 mid-RECV_HI -> all outputs 0 immediately; after release, state IDLE and bytes ignored until i_load.
- Three-word load: i_load, then bytes 0x01,0x08, 0x02,0x10, 0x00,0x00 ->
  - Writes addr0=0x0801, addr1=0x1002, addr2=0x0000, each with a one-cycle o_pm_wr.
  - o_enable rises 2 cycles after the last byte strobe; o_busy high throughout the load.
- Run/halt: in RUN, pulse i_cpu_halt -> o_enable=0 and o_done=1 next cycle.
  - Then i_load -> o_done=0; the next word is written at addr 0.
- Overflow: CELDAS=4, send 4 non-HALT words (e.g. 0x0801) -> 4 writes at addr 0..3, then o_error=1, o_enable stays 0.
  - Subsequent i_load recovers.
- Ignored events: i_rx_valid in IDLE and i_load during RUN -> no o_pm_wr, state unchanged.
- With BIP_LOADER_CHECKSUM_EN: bytes 0x01,0x08,0x00,0x00 then checksum 0x09 -> RUN.
  - Same load with checksum 0x0A -> ERROR, o_enable=0.
